result_checker: RTL and testbench
=================================

RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 32, result width.
- DEPTH, 8, expected-result FIFO depth; power of two, at least 2.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- i_clear  in  1  synchronous clear.
- i_exp_valid  in  1  golden-model result valid.
- o_exp_ready  out  1  FIFO can accept.
- i_exp_data  in  WIDTH  golden result.
- i_dut_valid  in  1  DUT result valid; no backpressure.
- i_dut_data  in  WIDTH  DUT result.
- o_freeze  out  1  no comparison this cycle; feeds scoreboard i_freeze.
- o_event  out  1  mismatch; feeds scoreboard i_event.
- o_underflow  out  1  sticky: DUT result arrived with FIFO empty.
- o_level  out  log2(DEPTH)+1  FIFO occupancy.
- o_err_exp  out  WIDTH  captured golden value.
- o_err_dut  out  WIDTH  captured DUT value.

Function
REQ-003 Push SHALL occur iff i_exp_valid && o_exp_ready; o_exp_ready = (o_level != DEPTH), with no pop-when-full bypass.
REQ-004 Compare SHALL occur iff i_dut_valid && FIFO non-empty && state==RUN; it pops the head.
REQ-005 Outputs SHALL be registered with latency 1: on the cycle after a compare, o_freeze=0 and o_event=(head!=i_dut_data); on every other cycle, o_freeze=1 and o_event=0.
REQ-006 o_event SHALL never be 1 while o_freeze=1.
REQ-007 Simultaneous push and compare SHALL leave o_level unchanged; no bypass, so a push into an empty FIFO is not comparable in the same cycle.
REQ-008 i_dut_valid with FIFO empty in RUN SHALL set o_underflow, discard the DUT value, and produce no compare.
REQ-009 Pointers SHALL wrap modulo DEPTH; o_level SHALL never exceed DEPTH or go below 0.
REQ-010 States SHALL be RUN and HALT. RUN->HALT on a mismatching compare only when the halt feature is compiled in. HALT->RUN on i_clear.
REQ-011 In HALT, o_freeze=1, o_event=0, pushes are still accepted, and DUT results are ignored without setting o_underflow.
REQ-012 i_clear SHALL empty the FIFO, clear o_underflow, o_err_exp and o_err_dut, enter RUN, and force o_freeze=1 and o_event=0 next cycle; i_clear takes precedence over a same-cycle push or compare.

Reset
REQ-013 reset SHALL asynchronously force: state RUN, FIFO empty, o_level=0, o_freeze=1, o_event=0, o_underflow=0, o_err_exp=0, o_err_dut=0.
REQ-014 FIFO storage SHALL not be reset; reset mid-stream discards all queued entries.

Configuration
REQ-015 With RESULT_CHECKER_HALT_EN defined:
- The first mismatching compare SHALL capture the golden value into o_err_exp and the DUT value into o_err_dut, together with o_event.
- It then enters HALT.
REQ-016 Without RESULT_CHECKER_HALT_EN:
- HALT SHALL be unreachable.
- o_err_exp and o_err_dut SHALL be tied to 0.
- Every mismatch pulses o_event and checking continues.

Structure
REQ-017 The shared package tb_pkg SHALL hold the RUN/HALT state encodings and the default WIDTH/DEPTH constants.
REQ-018 FIFO storage and pointers SHALL be a sub-module sync_fifo (WIDTH, DEPTH; push, pop, full, empty, level); result_checker owns the compare, FSM and flags.

Verification
REQ-019 Push 0x5, 0x7, then DUT 0x5, 0x7 on consecutive cycles -> two cycles of o_freeze=0 with o_event=0, then o_level=0.
REQ-020 Push 0x10, DUT 0x11 -> o_freeze=0 and o_event=1 for one cycle. With the macro: o_err_exp=0x10, o_err_dut=0x11, and a later DUT result gives o_freeze=1. Without the macro: checking continues.
REQ-021 DUT valid with FIFO empty -> o_underflow=1 held until i_clear, o_freeze stays 1, o_level stays 0.
REQ-022 Push DEPTH entries -> o_exp_ready=0. Then push plus DUT in the same cycle -> o_level=DEPTH-1 and the pushed value is dropped. Then 2*DEPTH further push/compare pairs -> all match across pointer wrap.
REQ-023 Assert reset asynchronously with o_level=3 mid-stream -> o_level=0 and o_freeze=1 immediately. Assert i_clear with push and DUT valid in the same cycle -> FIFO empty and no o_event.

Source files
------------

// File: rtl/tb_pkg.sv
// Shared definitions for result_checker: FSM state encodings and default sizing.
package tb_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding golden results for result_checker.
// Storage is not reset; pointers and level are. clear empties the FIFO and wins over push/pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             push_s;
  logic             pop_s;

  assign push_s = push && !full && !clear;
  assign pop_s  = pop && !empty && !clear;

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (level_r == (AW+1)'(DEPTH));
  assign empty = (level_r == (AW+1)'(0));
  assign level = level_r;

  // Storage write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= (AW+1)'(0);
    end else if (clear) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= (AW+1)'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/result_checker.sv
// Compares DUT results against queued golden results; drives scoreboard freeze/event.
// Optional feature: define RESULT_CHECKER_HALT_EN to capture the first mismatch and halt.
module result_checker
  import tb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clear,
  input  logic                     i_exp_valid,
  output logic                     o_exp_ready,
  input  logic [WIDTH-1:0]         i_exp_data,
  input  logic                     i_dut_valid,
  input  logic [WIDTH-1:0]         i_dut_data,
  output logic                     o_freeze,
  output logic                     o_event,
  output logic                     o_underflow,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [WIDTH-1:0]         o_err_exp,
  output logic [WIDTH-1:0]         o_err_dut
);

`ifdef RESULT_CHECKER_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  state_e                state_r;
  state_e                state_nxt_s;
  logic [WIDTH-1:0]      head_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  compare_s;
  logic                  mismatch_s;
  logic                  underflow_set_s;
  logic                  freeze_r;
  logic                  event_r;
  logic                  underflow_r;

  assign o_exp_ready     = !full_s;
  assign push_s          = i_exp_valid && o_exp_ready && !i_clear;
  assign compare_s       = i_dut_valid && !empty_s && (state_r == ST_RUN) && !i_clear;
  assign mismatch_s      = compare_s && (head_s != i_dut_data);
  assign underflow_set_s = i_dut_valid && empty_s && (state_r == ST_RUN) && !i_clear;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (i_clear),
    .push  (push_s),
    .pop   (compare_s),
    .wdata (i_exp_data),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .level (o_level)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: HALT only reachable with the halt feature compiled in
  always_comb begin
    state_nxt_s = state_r;
    if (i_clear) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mismatch_s && HALT_EN) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_HALT: state_nxt_s = ST_HALT;
        default: state_nxt_s = ST_RUN;
      endcase
    end
  end

  // Registered compare result and sticky underflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freeze_r    <= 1'b1;
      event_r     <= 1'b0;
      underflow_r <= 1'b0;
    end else if (i_clear) begin
      freeze_r    <= 1'b1;
      event_r     <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      freeze_r <= !compare_s;
      event_r  <= mismatch_s;
      if (underflow_set_s) begin
        underflow_r <= 1'b1;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  assign o_freeze    = freeze_r;
  assign o_event     = event_r;
  assign o_underflow = underflow_r;

`ifdef RESULT_CHECKER_HALT_EN
  logic [WIDTH-1:0] err_exp_r;
  logic [WIDTH-1:0] err_dut_r;

  // Capture the mismatching pair; only the first is seen since HALT stops compares
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_exp_r <= WIDTH'(0);
      err_dut_r <= WIDTH'(0);
    end else if (i_clear) begin
      err_exp_r <= WIDTH'(0);
      err_dut_r <= WIDTH'(0);
    end else if (mismatch_s) begin
      err_exp_r <= head_s;
      err_dut_r <= i_dut_data;
    end else begin
      err_exp_r <= err_exp_r;
      err_dut_r <= err_dut_r;
    end
  end

  assign o_err_exp = err_exp_r;
  assign o_err_dut = err_dut_r;
`else
  assign o_err_exp = WIDTH'(0);
  assign o_err_dut = WIDTH'(0);
`endif

endmodule

// File: tb/tb_result_checker.sv
// Scoreboard bench for result_checker: a queue-based reference model predicts each cycle's outputs.
// Honours RESULT_CHECKER_HALT_EN the same way the design does.
module tb_result_checker;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_clear = 1'b0;
  logic          i_exp_valid = 1'b0;
  logic          o_exp_ready;
  logic [W-1:0]  i_exp_data = '0;
  logic          i_dut_valid = 1'b0;
  logic [W-1:0]  i_dut_data = '0;
  logic          o_freeze;
  logic          o_event;
  logic          o_underflow;
  logic [LW-1:0] o_level;
  logic [W-1:0]  o_err_exp;
  logic [W-1:0]  o_err_dut;

  result_checker #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (i_clear),
    .i_exp_valid (i_exp_valid),
    .o_exp_ready (o_exp_ready),
    .i_exp_data  (i_exp_data),
    .i_dut_valid (i_dut_valid),
    .i_dut_data  (i_dut_data),
    .o_freeze    (o_freeze),
    .o_event     (o_event),
    .o_underflow (o_underflow),
    .o_level     (o_level),
    .o_err_exp   (o_err_exp),
    .o_err_dut   (o_err_dut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          freeze;
    logic          ev;
    logic          underflow;
    logic          ready;
    logic [LW-1:0] level;
    logic [W-1:0]  err_exp;
    logic [W-1:0]  err_dut;
  } exp_t;

  exp_t        sb_q[$];
  logic [W-1:0] mq[$];
  bit          halted = 1'b0;
  bit          m_underflow = 1'b0;
  logic [W-1:0] m_err_exp = '0;
  logic [W-1:0] m_err_dut = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: golden results are a plain queue; predicts the outputs after the next edge
  task automatic model_step(input bit ev, input logic [W-1:0] ed, input bit dv,
                            input logic [W-1:0] dd, input bit clr);
    exp_t e;
    bit can_push, was_empty, cmp, mis;
    logic [W-1:0] head;
    if (clr) begin
      mq.delete();
      m_underflow = 1'b0;
      m_err_exp = '0;
      m_err_dut = '0;
      halted = 1'b0;
      e.freeze = 1'b1;
      e.ev = 1'b0;
    end else begin
      can_push = (mq.size() != D);
      was_empty = (mq.size() == 0);
      cmp = dv && !was_empty && !halted;
      mis = 1'b0;
      if (cmp) begin
        head = mq.pop_front();
        mis = (head != dd);
`ifdef RESULT_CHECKER_HALT_EN
        if (mis) begin
          m_err_exp = head;
          m_err_dut = dd;
          halted = 1'b1;
        end
`endif
      end
      if (dv && was_empty && !halted) m_underflow = 1'b1;
      if (ev && can_push) mq.push_back(ed);
      e.freeze = !cmp;
      e.ev = mis;
    end
    e.underflow = m_underflow;
    e.level = LW'(mq.size());
    e.ready = (mq.size() != D);
    e.err_exp = m_err_exp;
    e.err_dut = m_err_dut;
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit ev, input logic [W-1:0] ed, input bit dv,
                       input logic [W-1:0] dd, input bit clr);
    @(negedge clk);
    i_exp_valid = ev;
    i_exp_data  = ed;
    i_dut_valid = dv;
    i_dut_data  = dd;
    i_clear     = clr;
    model_step(ev, ed, dv, dd, clr);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [W-1:0] head_or_rand();
    if (mq.size() > 0) return mq[0];
    return W'($urandom);
  endfunction

  // Monitor: pops one prediction per cycle and compares away from the edge
  always @(posedge clk) begin
    exp_t e;
    #2;
    chk("event_while_frozen", {63'd0, o_event & o_freeze}, 64'd0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("freeze", {63'd0, o_freeze}, {63'd0, e.freeze});
      chk("event", {63'd0, o_event}, {63'd0, e.ev});
      chk("underflow", {63'd0, o_underflow}, {63'd0, e.underflow});
      chk("exp_ready", {63'd0, o_exp_ready}, {63'd0, e.ready});
      chk("level", 64'(o_level), 64'(e.level));
      chk("err_exp", 64'(o_err_exp), 64'(e.err_exp));
      chk("err_dut", 64'(o_err_dut), 64'(e.err_dut));
    end
  end

  initial begin
    logic [W-1:0] r;
    // Reset state
    #12;
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_freeze", {63'd0, o_freeze}, 64'd1);
    chk("rst_event", {63'd0, o_event}, 64'd0);
    chk("rst_underflow", {63'd0, o_underflow}, 64'd0);
    chk("rst_err_exp", 64'(o_err_exp), 64'd0);
    chk("rst_ready", {63'd0, o_exp_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Two matching compares in a row
    drive(1'b1, 32'h5, 1'b0, '0, 1'b0);
    drive(1'b1, 32'h7, 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 32'h5, 1'b0);
    drive(1'b0, '0, 1'b1, 32'h7, 1'b0);
    idle(2);

    // Mismatch, then a later DUT result (halted or still checking)
    drive(1'b1, 32'h10, 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 32'h11, 1'b0);
    drive(1'b1, 32'h20, 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 32'h20, 1'b0);
    idle(2);
    drive(1'b0, '0, 1'b0, '0, 1'b1);

    // Underflow sticks until clear
    drive(1'b0, '0, 1'b1, 32'h33, 1'b0);
    idle(3);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    idle(1);

    // Fill, push while full plus compare, then pairs across pointer wrap
    for (int k = 0; k < D; k++) drive(1'b1, W'($urandom), 1'b0, '0, 1'b0);
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, head_or_rand(), 1'b0);
    for (int k = 0; k < 2 * D; k++) drive(1'b1, W'($urandom), 1'b1, head_or_rand(), 1'b0);
    for (int k = 0; k < D; k++) drive(1'b0, '0, 1'b1, head_or_rand(), 1'b0);
    idle(1);

    // Randomized traffic with occasional mismatches and clears
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(9) == 0) ? W'($urandom) : head_or_rand();
      drive(1'($urandom_range(1)), W'($urandom), 1'($urandom_range(1)), r,
            1'($urandom_range(49) == 0));
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);

    // Asynchronous reset mid-stream with three entries queued
    for (int k = 0; k < 3; k++) drive(1'b1, W'($urandom), 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #4;
    chk("pre_rst_level", 64'(o_level), 64'd3);
    reset = 1'b1;
    #1;
    chk("async_rst_level", 64'(o_level), 64'd0);
    chk("async_rst_freeze", {63'd0, o_freeze}, 64'd1);
    mq.delete();
    halted = 1'b0;
    m_underflow = 1'b0;
    m_err_exp = '0;
    m_err_dut = '0;
    @(negedge clk);
    reset = 1'b0;

    // Clear beats a same-cycle push and compare
    drive(1'b1, 32'hA1, 1'b0, '0, 1'b0);
    drive(1'b1, 32'hA2, 1'b0, '0, 1'b0);
    drive(1'b1, 32'hA3, 1'b1, 32'hFF, 1'b1);
    idle(2);

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
